// File: rtl/microwave_power_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : microwave_power_ctrl
//  Purpose  : Microwave front-panel controller. Handles keypad digit entry,
//             a base-60 countdown with 1-2 minute digits, magnetron power
//             duty cycling, pause/resume and a completion state. Drives the
//             seven-segment displays.
//  Options  : MICROWAVE_BEEP_EN - when defined, a completion beep of
//             BEEP_SECONDS seconds is generated. Otherwise beep is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module microwave_power_ctrl #(
  parameter int MIN_DIGITS    = 1,
  parameter int TICKS_PER_SEC = 100,
  parameter int BEEP_SECONDS  = 3
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [9:0]              keypad,
  input  logic                    startn,
  input  logic                    stopn,
  input  logic                    clearn,
  input  logic                    door_closed,
  input  logic [3:0]              power_level,
  output logic [6:0]              sec_ones_segs,
  output logic [6:0]              sec_tens_segs,
  output logic [7*MIN_DIGITS-1:0] min_segs,
  output logic                    mag_on,
  output logic                    done,
  output logic                    beep
);

  // Digit 0 is seconds ones, digit 1 is seconds tens, digits 2.. are minutes.
  localparam int C_NDIG = MIN_DIGITS + 2;
  localparam int C_TW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [C_TW-1:0] C_TICK_LAST = C_TW'(TICKS_PER_SEC - 1);

  if (MIN_DIGITS < 1 || MIN_DIGITS > 2 || TICKS_PER_SEC < 2 || BEEP_SECONDS < 1) begin : g_param_check
    $error("microwave_power_ctrl: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [C_NDIG*4-1:0]     r_time, w_time_nxt, w_time_dec;
  logic [C_TW-1:0]         r_tick, w_tick_nxt;
  logic [3:0]              r_window, w_window_nxt;
  logic [3:0]              r_level, w_level_nxt, w_level_in;
  logic                    r_startn_q, r_stopn_q, r_clearn_q;
  logic [9:0]              r_keypad_q;
  logic                    w_start_p, w_stop_p, w_clear_p, w_key_p, w_sec_tick;
  logic [3:0]              w_digit;

  // Decimal decrement with a base-60 borrow out of the seconds-tens digit.
  function automatic logic [C_NDIG*4-1:0] dec_time(input logic [C_NDIG*4-1:0] t);
    logic [C_NDIG*4-1:0] res;
    logic                borrow;
    res    = t;
    borrow = 1'b1;
    for (int i = 0; i < C_NDIG; i++) begin
      if (borrow) begin
        if (t[i*4 +: 4] == 4'd0) begin
          res[i*4 +: 4] = (i == 1) ? 4'd5 : 4'd9;
        end else begin
          res[i*4 +: 4] = t[i*4 +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Previous input levels for press (edge) detection, reset to idle levels.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_startn_q <= 1'b1;
      r_stopn_q  <= 1'b1;
      r_clearn_q <= 1'b1;
      r_keypad_q <= '0;
    end else begin
      r_startn_q <= startn;
      r_stopn_q  <= stopn;
      r_clearn_q <= clearn;
      r_keypad_q <= keypad;
    end
  end

  assign w_start_p  = r_startn_q & ~startn;
  assign w_stop_p   = r_stopn_q  & ~stopn;
  assign w_clear_p  = r_clearn_q & ~clearn;
  assign w_key_p    = (r_keypad_q == 10'd0) & $onehot(keypad);
  assign w_sec_tick = (r_tick == C_TICK_LAST);
  assign w_time_dec = dec_time(r_time);
  assign w_level_in = (power_level > 4'd10) ? 4'd10 : power_level;

  // One-hot keypad to digit value; only meaningful when w_key_p is set.
  always_comb begin
    w_digit = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (keypad[i]) w_digit = 4'(i);
    end
  end

  // Next-state and datapath update; priority clear > stop > start > digit.
  always_comb begin
    w_state_nxt  = r_state;
    w_time_nxt   = r_time;
    w_tick_nxt   = r_tick;
    w_window_nxt = r_window;
    w_level_nxt  = r_level;
    case (r_state)
      S_IDLE: begin
        if (!w_clear_p && !w_stop_p && !w_start_p && w_key_p) begin
          w_state_nxt = S_SET;
          w_time_nxt  = {r_time[C_NDIG*4-5:0], w_digit};
        end
      end
      S_SET: begin
        if (w_clear_p) begin
          w_state_nxt = S_IDLE;
          w_time_nxt  = '0;
        end else if (w_stop_p) begin
          w_state_nxt = S_SET;
        end else if (w_start_p) begin
          if (door_closed && (r_time != '0)) begin
            w_state_nxt  = S_RUN;
            w_tick_nxt   = '0;
            w_window_nxt = 4'd0;
            w_level_nxt  = w_level_in;
          end
        end else if (w_key_p) begin
          w_time_nxt = {r_time[C_NDIG*4-5:0], w_digit};
        end
      end
      S_RUN: begin
        if (w_clear_p) begin
          w_state_nxt = S_IDLE;
          w_time_nxt  = '0;
        end else if (w_stop_p || !door_closed) begin
          w_state_nxt = S_PAUSE;
        end else if (w_sec_tick) begin
          w_tick_nxt   = '0;
          w_time_nxt   = w_time_dec;
          w_window_nxt = (r_window == 4'd9) ? 4'd0 : r_window + 4'd1;
          if (w_time_dec == '0) w_state_nxt = S_DONE;
        end else begin
          w_tick_nxt = r_tick + C_TW'(1);
        end
      end
      S_PAUSE: begin
        if (w_clear_p || w_stop_p) begin
          w_state_nxt = S_IDLE;
          w_time_nxt  = '0;
        end else if (w_start_p && door_closed) begin
          w_state_nxt = S_RUN;
          w_tick_nxt  = '0;
          w_level_nxt = w_level_in;
        end
      end
      S_DONE: begin
        if (w_clear_p || w_stop_p || !door_closed) begin
          w_state_nxt = S_IDLE;
          w_time_nxt  = '0;
        end else if (!w_start_p && w_key_p) begin
          w_state_nxt = S_SET;
          w_time_nxt  = {{(C_NDIG*4-4){1'b0}}, w_digit};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_time_nxt  = '0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_time   <= '0;
      r_tick   <= '0;
      r_window <= 4'd0;
      r_level  <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_time   <= w_time_nxt;
      r_tick   <= w_tick_nxt;
      r_window <= w_window_nxt;
      r_level  <= w_level_nxt;
    end
  end

  assign sec_ones_segs = seg7(r_time[3:0]);
  assign sec_tens_segs = seg7(r_time[7:4]);

  for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min_segs
    assign min_segs[g*7 +: 7] = seg7(r_time[(g+2)*4 +: 4]);
  end

  // Door gating is combinational so an opening door cuts power immediately.
  assign mag_on = (r_state == S_RUN) & door_closed & (r_window < r_level);
  assign done   = (r_state == S_DONE);

`ifdef MICROWAVE_BEEP_EN
  localparam int C_BEEP_CYC = BEEP_SECONDS * TICKS_PER_SEC;
  localparam int C_BW       = $clog2(C_BEEP_CYC + 1);
  logic [C_BW-1:0] r_beep_cnt;

  // Beep length counter: loaded on DONE entry, counts down while in DONE.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_beep_cnt <= '0;
    end else if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
      r_beep_cnt <= C_BW'(C_BEEP_CYC);
    end else if (r_state != S_DONE) begin
      r_beep_cnt <= '0;
    end else if (r_beep_cnt != '0) begin
      r_beep_cnt <= r_beep_cnt - C_BW'(1);
    end
  end

  assign beep = (r_state == S_DONE) & (r_beep_cnt != '0);
`else
  assign beep = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_microwave_power_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_microwave_power_ctrl
//  Purpose  : Directed self-checking bench for microwave_power_ctrl with
//             TICKS_PER_SEC=4, MIN_DIGITS=1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_microwave_power_ctrl;

  logic       clock = 1'b0;
  logic       resetn;
  logic [9:0] keypad;
  logic       startn, stopn, clearn, door_closed;
  logic [3:0] power_level;
  logic [6:0] sec_ones_segs, sec_tens_segs, min_segs;
  logic       mag_on, done, beep;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S7 = 7'h07, S9 = 7'h6F;

`ifdef MICROWAVE_BEEP_EN
  localparam logic BEEP_EXP = 1'b1;
`else
  localparam logic BEEP_EXP = 1'b0;
`endif

  microwave_power_ctrl #(
    .MIN_DIGITS    (1),
    .TICKS_PER_SEC (4),
    .BEEP_SECONDS  (3)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .keypad        (keypad),
    .startn        (startn),
    .stopn         (stopn),
    .clearn        (clearn),
    .door_closed   (door_closed),
    .power_level   (power_level),
    .sec_ones_segs (sec_ones_segs),
    .sec_tens_segs (sec_tens_segs),
    .min_segs      (min_segs),
    .mag_on        (mag_on),
    .done          (done),
    .beep          (beep)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_disp(input string tag, input logic [6:0] m, input logic [6:0] t,
                            input logic [6:0] o);
    check({tag, "_min"},  {25'd0, min_segs},      {25'd0, m});
    check({tag, "_tens"}, {25'd0, sec_tens_segs}, {25'd0, t});
    check({tag, "_ones"}, {25'd0, sec_ones_segs}, {25'd0, o});
  endtask

  task automatic press_key(input int d);
    keypad = 10'(1 << d);
    tick();
    keypad = '0;
    tick();
  endtask

  task automatic press_clear();
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
    tick();
  endtask

  initial begin
    resetn      = 1'b0;
    keypad      = '0;
    startn      = 1'b1;
    stopn       = 1'b1;
    clearn      = 1'b1;
    door_closed = 1'b1;
    power_level = 4'd10;
    tick(2);
    check_disp("reset", S0, S0, S0);
    check("reset_mag", {31'd0, mag_on}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_beep", {31'd0, beep}, 32'd0);
    resetn = 1'b1;
    tick();

    // Full cook of 0:10 at power 10
    press_key(1);
    check_disp("entry1", S0, S0, S1);
    press_key(0);
    check_disp("entry10", S0, S1, S0);
    startn = 1'b0;
    tick();
    startn = 1'b1;
    check_disp("run_start", S0, S1, S0);
    check("run_mag", {31'd0, mag_on}, 32'd1);
    tick(4);
    check_disp("run_first_dec", S0, S0, S9);
    tick(35);
    check_disp("run_0_01", S0, S0, S1);
    check("run_not_done", {31'd0, done}, 32'd0);
    tick();
    check_disp("done_disp", S0, S0, S0);
    check("done_flag", {31'd0, done}, 32'd1);
    check("done_mag", {31'd0, mag_on}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("beep_on", {31'd0, beep}, {31'd0, BEEP_EXP});
      tick();
    end
    check("beep_off", {31'd0, beep}, 32'd0);
    check("done_hold", {31'd0, done}, 32'd1);
    press_key(3);
    check("done_to_set", {31'd0, done}, 32'd0);
    check_disp("done_digit", S0, S0, S3);
    press_clear();
    check_disp("clear_after_set", S0, S0, S0);

    // Minute borrow: 1:05 -> 0:59 after 24 cycles
    press_key(1);
    press_key(0);
    press_key(5);
    check_disp("entry105", S1, S0, S5);
    startn = 1'b0;
    tick();
    startn = 1'b1;
    check_disp("run105", S1, S0, S5);
    tick(20);
    check_disp("run100", S1, S0, S0);
    tick(4);
    check_disp("run059", S0, S5, S9);
    press_clear();

    // Power 3 duty cycle, level latched at RUN entry
    power_level = 4'd3;
    press_key(2);
    press_key(0);
    startn = 1'b0;
    tick();
    startn = 1'b1;
    power_level = 4'd15;
    for (int i = 0; i < 40; i++) begin
      check("duty", {31'd0, mag_on}, (i < 12) ? 32'd1 : 32'd0);
      tick();
    end
    check("duty_wrap", {31'd0, mag_on}, 32'd1);
    press_clear();

    // Door open pauses, start resumes from held value
    power_level = 4'd10;
    press_key(5);
    startn = 1'b0;
    tick();
    startn = 1'b1;
    check("pause_run_mag", {31'd0, mag_on}, 32'd1);
    tick(4);
    check_disp("pause_pre", S0, S0, S4);
    tick();
    door_closed = 1'b0;
    #1;
    check("door_mag_drop", {31'd0, mag_on}, 32'd0);
    tick();
    tick(8);
    check_disp("paused_hold", S0, S0, S4);
    door_closed = 1'b1;
    #1;
    check("paused_mag", {31'd0, mag_on}, 32'd0);
    tick();
    startn = 1'b0;
    tick();
    startn = 1'b1;
    check("resume_mag", {31'd0, mag_on}, 32'd1);
    check_disp("resume_disp", S0, S0, S4);
    tick(3);
    check_disp("resume_hold", S0, S0, S4);
    tick();
    check_disp("resume_dec", S0, S0, S3);
    stopn = 1'b0;
    tick();
    stopn = 1'b1;
    check("stop_mag", {31'd0, mag_on}, 32'd0);
    tick(8);
    check_disp("stop_hold", S0, S0, S3);
    stopn = 1'b0;
    tick();
    stopn = 1'b1;
    tick();
    check_disp("stop_idle", S0, S0, S0);

    // Clear beats start; start ignored with door open; entry shifting
    press_key(3);
    clearn = 1'b0;
    startn = 1'b0;
    tick();
    clearn = 1'b1;
    startn = 1'b1;
    check_disp("clr_start", S0, S0, S0);
    check("clr_start_mag", {31'd0, mag_on}, 32'd0);
    tick(8);
    check_disp("clr_idle_hold", S0, S0, S0);
    press_key(7);
    door_closed = 1'b0;
    startn = 1'b0;
    tick();
    startn = 1'b1;
    check("door_open_start", {31'd0, mag_on}, 32'd0);
    tick(8);
    check_disp("door_open_hold", S0, S0, S7);
    door_closed = 1'b1;
    press_key(2);
    check_disp("entry072", S0, S7, S2);
    press_key(9);
    check_disp("entry729", S7, S2, S9);
    keypad = 10'b0000000110;
    tick();
    keypad = '0;
    tick();
    check_disp("multibit_ignored", S7, S2, S9);
    press_key(4);
    check_disp("entry294", S2, S9, S4);
    press_clear();

    // Asynchronous reset mid-run
    press_key(8);
    startn = 1'b0;
    tick();
    startn = 1'b1;
    tick(2);
    resetn = 1'b0;
    #1;
    check_disp("async_reset", S0, S0, S0);
    check("async_reset_mag", {31'd0, mag_on}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/microwave_power_ctrl.md
# microwave_power_ctrl

Parametrised successor to the single-minute microwave controller: keypad digit entry, base-60 countdown with multi-digit minutes, magnetron power-level duty cycling, pause/resume and a completion state. It sits between the front-panel keypad/buttons and the seven-segment display and magnetron driver. All control inputs are synchronous to `clock`.

## Interface
- `MIN_DIGITS`, 1: number of minute digits (1–2).
- `TICKS_PER_SEC`, 100: `clock` cycles per second (100 Hz clock).
- `BEEP_SECONDS`, 3: beep duration on completion (used only with `MICROWAVE_BEEP_EN`).
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are `clock` and `resetn`.
- `clock` in 1: system clock, rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `keypad` in 10: one-hot digit keys, bit i = digit i.
- `startn`, `stopn`, `clearn` in 1 each: active-low buttons.
- `door_closed` in 1: 1 = door closed.
- `power_level` in 4: 0–10; values >10 are clamped to 10.
- `sec_ones_segs`, `sec_tens_segs` out 7 each: seconds digits.
- `min_segs` out 7*MIN_DIGITS: minute digits, least-significant digit in bits [6:0].
- `mag_on` out 1: magnetron enable.
- `done` out 1: cook complete.
- `beep` out 1: completion tone.

## Operation
- Segments active-high, seg[0]=a … seg[6]=g. Digit 0 = 7'h3F.
- Press detection: a press is a 1→0 transition on a button, or a keypad transition from 0 to exactly one bit set. Multi-bit keypad values are ignored. Edge registers reset to idle levels (buttons 1, keypad 0).
- Priority for simultaneous presses: clear > stop > start > digit.
- Digit entry shifts left. The new digit goes into sec_ones; the old sec_ones moves to sec_tens, then up through the minute digits. The top digit falls off. sec_tens may hold 6–9; for example, 0:99 counts 99…60, 59….
- States and transitions:
  - IDLE: all digits 0. Digit → SET.
  - SET: digit shifts in. Clear → IDLE. Start → RUN only if `door_closed`=1 and the time is non-zero; otherwise start is ignored.
  - RUN:
    - Ticks are counted; each second the time decrements. At 00 seconds, borrow a minute and reload seconds to 59.
    - Reaching all-zero → DONE.
    - Door opens or stop pressed → PAUSE.
    - Clear → IDLE.
    - Digits are ignored.
  - PAUSE: Start with door closed → RUN. Clear or stop → IDLE. Digits are ignored.
  - DONE: `done`=1 and display shows 0. Clear, stop or door opening → IDLE. Digit → SET with that digit.
- Power duty cycle:
  - `power_level` is latched on each entry to RUN.
  - A window counter runs 0–9 and advances once per second. It resets on SET→RUN and is preserved across PAUSE.
  - mag_on = (state==RUN) & door_closed & (window < level).
  - Level 0 means the magnetron never turns on. Level 10 means it is always on.
- The tick counter clears on every entry to RUN.

## Timing
- A press takes effect at the first rising edge where the new level is sampled. State and display update at that edge.
- First decrement occurs TICKS_PER_SEC cycles after RUN entry, then every TICKS_PER_SEC cycles.
- The transition to DONE happens at the same edge that makes the time 0:00. `mag_on` and `done` change at that edge.
- `mag_on` is gated combinationally by `door_closed`, so opening the door drops it in the same cycle, before the PAUSE edge.
- Reset mid-operation: asynchronous return to IDLE.
- Reset values: all displays 7'h3F, `mag_on`=0, `done`=0, `beep`=0.

## Configuration
- `MICROWAVE_BEEP_EN` defined: `beep`=1 for BEEP_SECONDS*TICKS_PER_SEC cycles, starting at DONE entry. It clears early if DONE is left.
- `MICROWAVE_BEEP_EN` undefined: the `beep` port still exists and is tied to 0; no beep counter is built.

## Test plan
All scenarios use TICKS_PER_SEC=4 and MIN_DIGITS=1.
- Enter digits 1,0 with power 10, door closed, then start → display 0:10, `mag_on`=1. After 40 cycles the block reaches DONE: display 0:00, `done`=1, `mag_on`=0.
- Enter 1,0,5 then start → display 1:05. 24 cycles later display shows 0:59.
- Power 3, run 0:20 → `mag_on` high for 12 cycles, low for 28, repeating.
- Open the door in RUN → `mag_on` drops the same cycle and the state is PAUSE. Close the door and press start → countdown resumes from the held value.
- Assert clear and start in the same cycle while in SET → IDLE with 0:00. Start with door open → remains in SET.
- With `MICROWAVE_BEEP_EN`: `beep` is high for 12 cycles after DONE. Without it: `beep` stays 0 throughout.
